// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operand/result converters and the
// multiply/divide datapath.
//   - 5-bit ALU opcode constants for the multiply/divide group
//   - result_converter state encoding
//   - default data word width
//   - sign tag record captured at issue, plus opcode decode helpers
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;

  localparam logic [4:0] OP_MUL    = 5'b00010;
  localparam logic [4:0] OP_MULH   = 5'b00011;
  localparam logic [4:0] OP_MULHSU = 5'b00100;
  localparam logic [4:0] OP_MULHU  = 5'b00101;
  localparam logic [4:0] OP_DIV    = 5'b00110;
  localparam logic [4:0] OP_DIVU   = 5'b00111;
  localparam logic [4:0] OP_REM    = 5'b01000;
  localparam logic [4:0] OP_REMU   = 5'b01001;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_RES = 3'd1;
  localparam logic [2:0] ST_NEG_LO   = 3'd2;
  localparam logic [2:0] ST_NEG_HI   = 3'd3;
  localparam logic [2:0] ST_OUT      = 3'd4;

  typedef struct packed {
    logic [4:0] opcode;
    logic       sign_1;
    logic       sign_2;
    logic       div_zero;
  } sign_tag_t;

  // Whether the core's unsigned result must be negated for this opcode.
  function automatic logic op_needs_neg(input logic [4:0] op, input logic s1, input logic s2);
    logic neg;
    neg = 1'b0;
    case (op)
      OP_MUL, OP_MULH, OP_DIV: neg = s1 ^ s2;
      OP_MULHSU, OP_REM:       neg = s1;
      default:                 neg = 1'b0;
    endcase
    return neg;
  endfunction

  // Whether the result comes from the high word (product high / remainder).
  function automatic logic op_selects_hi(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU) ||
           (op == OP_REM)  || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/word_negator.sv
// ---------------------------------------------------------------------------
// word_negator
// Computes ~i_x + i_cin with carry out; the building block for two's
// complement negation of single words and of chained 64-bit products.
// Ports:
//   i_x    in  WIDTH  word to invert
//   i_cin  in  1      carry in (1 for the low/only word, chained carry above)
//   o_y    out WIDTH  ~i_x + i_cin
//   o_cout out 1      carry out into the next word
// ---------------------------------------------------------------------------
module word_negator #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_y,
  output logic             o_cout
);

  assign {o_cout, o_y} = {1'b0, ~i_x} + {{WIDTH{1'b0}}, i_cin};

endmodule

// File: rtl/result_converter.sv
// ---------------------------------------------------------------------------
// result_converter
// Restores the sign on the unsigned magnitude produced by the multiply/divide
// core. The sign tag is captured at issue, the core result is captured when
// it arrives, the selected word is negated if required, and the 32-bit result
// is offered on a valid/ready port towards writeback.
//
// Build option:
//   RESULT_CONV_FAST_NEG_EN  defined: 64-bit negation in one cycle (two chained
//                            negators, no NEG_HI state); undefined: split
//                            low/high negation over two cycles.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   issue_valid     in  sign tag offered
//   issue_ready     out idle, tag accepted
//   issue_opcode    in  ALU opcode
//   issue_sign_1/2  in  sign bits of the original operands
//   issue_div_zero  in  divisor is zero
//   issue_dividend  in  original operand 1 (returned by REM/REMU by zero)
//   res_valid       in  core result pulse, sampled only while waiting
//   res_hi/res_lo   in  product halves or remainder/quotient magnitudes
//   out_valid       out result available
//   out_ready       in  consumer accepts
//   out_result      out sign-corrected result
//   busy            out tag held
// ---------------------------------------------------------------------------
module result_converter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [4:0]       issue_opcode,
  input  logic             issue_sign_1,
  input  logic             issue_sign_2,
  input  logic             issue_div_zero,
  input  logic [WIDTH-1:0] issue_dividend,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_hi,
  input  logic [WIDTH-1:0] res_lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);

  logic [2:0]       r_state;
  sign_tag_t        r_tag;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_result;
  logic             r_sel_hi;
  // Negated high word of a product: needs the carry out of the low word.
  logic             r_chain;

  logic w_neg;
  logic w_sel_hi;
  logic w_is_mul;
  logic w_is_div;
  logic w_is_rem;

  assign w_neg    = op_needs_neg(r_tag.opcode, r_tag.sign_1, r_tag.sign_2);
  assign w_sel_hi = op_selects_hi(r_tag.opcode);
  assign w_is_mul = (r_tag.opcode == OP_MUL)    || (r_tag.opcode == OP_MULH) ||
                    (r_tag.opcode == OP_MULHSU) || (r_tag.opcode == OP_MULHU);
  assign w_is_div = (r_tag.opcode == OP_DIV) || (r_tag.opcode == OP_DIVU);
  assign w_is_rem = (r_tag.opcode == OP_REM) || (r_tag.opcode == OP_REMU);

`ifdef RESULT_CONV_FAST_NEG_EN
  logic [WIDTH-1:0] w_lo_n;
  logic             w_lo_cout;
  logic [WIDTH-1:0] w_hi_n;
  logic             w_hi_cout;
  logic             w_hi_cin;

  // REM negates the remainder word on its own; products chain the low carry.
  assign w_hi_cin = r_chain ? w_lo_cout : 1'b1;

  word_negator #(.WIDTH(WIDTH)) u_neg_lo (
    .i_x    (r_lo),
    .i_cin  (1'b1),
    .o_y    (w_lo_n),
    .o_cout (w_lo_cout)
  );

  word_negator #(.WIDTH(WIDTH)) u_neg_hi (
    .i_x    (r_hi),
    .i_cin  (w_hi_cin),
    .o_y    (w_hi_n),
    .o_cout (w_hi_cout)
  );
`else
  logic [WIDTH-1:0] w_neg_in;
  logic             w_neg_cin;
  logic [WIDTH-1:0] w_neg_y;
  logic             w_neg_cout;
  logic             r_carry;

  // One shared negator: low word (or REM's high word) in NEG_LO, then the
  // product high word with the stored carry in NEG_HI.
  always_comb begin
    w_neg_in  = r_lo;
    w_neg_cin = 1'b1;
    if (r_state == ST_NEG_HI) begin
      w_neg_in  = r_hi;
      w_neg_cin = r_carry;
    end else if (r_sel_hi && !r_chain) begin
      w_neg_in  = r_hi;
    end
  end

  word_negator #(.WIDTH(WIDTH)) u_neg (
    .i_x    (w_neg_in),
    .i_cin  (w_neg_cin),
    .o_y    (w_neg_y),
    .o_cout (w_neg_cout)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_tag      <= '0;
      r_dividend <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_result   <= '0;
      r_sel_hi   <= 1'b0;
      r_chain    <= 1'b0;
`ifndef RESULT_CONV_FAST_NEG_EN
      r_carry    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (issue_valid) begin
            r_tag.opcode   <= issue_opcode;
            r_tag.sign_1   <= issue_sign_1;
            r_tag.sign_2   <= issue_sign_2;
            r_tag.div_zero <= issue_div_zero;
            r_dividend     <= issue_dividend;
            r_state        <= ST_WAIT_RES;
          end
        end
        ST_WAIT_RES: begin
          if (res_valid) begin
            r_hi     <= res_hi;
            r_lo     <= res_lo;
            r_sel_hi <= w_sel_hi;
            r_chain  <= w_neg && w_sel_hi && w_is_mul;
            if (r_tag.div_zero && w_is_div) begin
              r_result <= '1;
              r_state  <= ST_OUT;
            end else if (r_tag.div_zero && w_is_rem) begin
              r_result <= r_dividend;
              r_state  <= ST_OUT;
            end else if (!w_neg) begin
              r_result <= w_sel_hi ? res_hi : res_lo;
              r_state  <= ST_OUT;
            end else begin
              r_state  <= ST_NEG_LO;
            end
          end
        end
        ST_NEG_LO: begin
`ifdef RESULT_CONV_FAST_NEG_EN
          r_result <= r_sel_hi ? w_hi_n : w_lo_n;
          r_state  <= ST_OUT;
`else
          if (r_chain) begin
            r_carry <= w_neg_cout;
            r_state <= ST_NEG_HI;
          end else begin
            r_result <= w_neg_y;
            r_state  <= ST_OUT;
          end
`endif
        end
`ifndef RESULT_CONV_FAST_NEG_EN
        ST_NEG_HI: begin
          r_result <= w_neg_y;
          r_state  <= ST_OUT;
        end
`endif
        ST_OUT: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef RESULT_CONV_FAST_NEG_EN
  logic w_unused;
  assign w_unused = w_hi_cout;
`else
  logic w_unused;
  assign w_unused = 1'b0;
`endif

  assign issue_ready = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign out_valid   = (r_state == ST_OUT);
  assign out_result  = r_result;

endmodule

// File: tb/tb_result_converter.sv
module tb_result_converter;

  localparam logic [4:0] MUL    = 5'd2;
  localparam logic [4:0] MULH   = 5'd3;
  localparam logic [4:0] MULHSU = 5'd4;
  localparam logic [4:0] MULHU  = 5'd5;
  localparam logic [4:0] DIV    = 5'd6;
  localparam logic [4:0] DIVU   = 5'd7;
  localparam logic [4:0] REM    = 5'd8;
  localparam logic [4:0] REMU   = 5'd9;

`ifdef RESULT_CONV_FAST_NEG_EN
  localparam int LAT_HI = 2;
`else
  localparam int LAT_HI = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [4:0]  issue_opcode = '0;
  logic        issue_sign_1 = 1'b0;
  logic        issue_sign_2 = 1'b0;
  logic        issue_div_zero = 1'b0;
  logic [31:0] issue_dividend = '0;
  logic        res_valid = 1'b0;
  logic [31:0] res_hi = '0;
  logic [31:0] res_lo = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  result_converter #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_opcode   (issue_opcode),
    .issue_sign_1   (issue_sign_1),
    .issue_sign_2   (issue_sign_2),
    .issue_div_zero (issue_div_zero),
    .issue_dividend (issue_dividend),
    .res_valid      (res_valid),
    .res_hi         (res_hi),
    .res_lo         (res_lo),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .busy           (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: signed result from 64-bit / 32-bit two's complement arithmetic.
  function automatic void model(input logic [4:0] op, input logic s1, input logic s2,
                                input logic dz, input logic [31:0] dvd,
                                input logic [31:0] hi, input logic [31:0] lo,
                                output logic [31:0] r, output int lat);
    logic [63:0] mag;
    logic [63:0] sgn;
    logic [31:0] w;
    logic        neg;
    logic        hi_sel;
    logic        is_mul;
    mag    = {hi, lo};
    neg    = 1'b0;
    hi_sel = 1'b0;
    case (op)
      MUL:    neg = s1 ^ s2;
      MULH:   begin neg = s1 ^ s2; hi_sel = 1'b1; end
      MULHSU: begin neg = s1; hi_sel = 1'b1; end
      MULHU:  hi_sel = 1'b1;
      DIV:    neg = s1 ^ s2;
      REM:    begin neg = s1; hi_sel = 1'b1; end
      REMU:   hi_sel = 1'b1;
      default: ;
    endcase
    is_mul = (op == MUL) || (op == MULH) || (op == MULHSU) || (op == MULHU);
    if (dz && (op == DIV || op == DIVU)) begin
      r   = 32'hFFFF_FFFF;
      lat = 1;
    end else if (dz && (op == REM || op == REMU)) begin
      r   = dvd;
      lat = 1;
    end else begin
      if (is_mul) begin
        sgn = neg ? 64'd0 - mag : mag;
        r   = hi_sel ? sgn[63:32] : sgn[31:0];
      end else begin
        w = hi_sel ? hi : lo;
        r = neg ? 32'd0 - w : w;
      end
      if (!neg)                  lat = 1;
      else if (hi_sel && is_mul) lat = LAT_HI;
      else                       lat = 2;
    end
  endfunction

  // Called on a negedge with out_ready=1; returns on a negedge with DUT idle.
  task automatic do_op(input string name, input logic [4:0] op, input logic s1,
                       input logic s2, input logic dz, input logic [31:0] dvd,
                       input logic [31:0] hi, input logic [31:0] lo,
                       input logic [31:0] exp_r, input int exp_lat);
    int lat;
    check({name, ".issue_ready"}, 32'(issue_ready), 32'd1);
    issue_valid    = 1'b1;
    issue_opcode   = op;
    issue_sign_1   = s1;
    issue_sign_2   = s2;
    issue_div_zero = dz;
    issue_dividend = dvd;
    @(negedge clk);
    issue_valid    = 1'b0;
    issue_opcode   = 5'($urandom);
    issue_sign_1   = 1'($urandom);
    issue_sign_2   = 1'($urandom);
    issue_div_zero = 1'($urandom);
    issue_dividend = $urandom;
    res_valid = 1'b1;
    res_hi    = hi;
    res_lo    = lo;
    @(negedge clk);
    res_valid = 1'b0;
    res_hi    = $urandom;
    res_lo    = $urandom;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({name, ".latency"}, 32'(lat), 32'(exp_lat));
    check({name, ".result"}, out_result, exp_r);
    @(negedge clk);
    check({name, ".out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic        s1;
    logic        s2;
    logic        dz;
    logic [31:0] dvd;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] exp_r;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [31:0] r_exp;
    int          l_exp;
    logic [4:0]  op;
    logic        s1, s2, dz;
    logic [31:0] dvd, hi, lo;

    vecs[0]  = '{"mul_m3x5",      MUL,    1, 0, 0, 32'h0,        32'h0,        32'd15,       32'hFFFF_FFF1, 2};
    vecs[1]  = '{"mulh_m1x1",     MULH,   1, 0, 0, 32'h0,        32'h0,        32'd1,        32'hFFFF_FFFF, LAT_HI};
    vecs[2]  = '{"mulh_carry",    MULH,   0, 1, 0, 32'h0,        32'd5,        32'd0,        32'hFFFF_FFFB, LAT_HI};
    vecs[3]  = '{"div_zero",      DIV,    1, 0, 1, 32'hFFFF_FFF9, 32'h1234,    32'h5678,     32'hFFFF_FFFF, 1};
    vecs[4]  = '{"rem_zero",      REM,    1, 0, 1, 32'hFFFF_FFF9, 32'h1234,    32'h5678,     32'hFFFF_FFF9, 1};
    vecs[5]  = '{"rem_m7_2",      REM,    1, 0, 0, 32'h0,        32'd1,        32'd3,        32'hFFFF_FFFF, 2};
    vecs[6]  = '{"divu_big",      DIVU,   1, 0, 0, 32'h0,        32'h0,        32'h8000_0000, 32'h8000_0000, 1};
    vecs[7]  = '{"div_ovf",       DIV,    1, 1, 0, 32'h0,        32'h0,        32'h8000_0000, 32'h8000_0000, 1};
    vecs[8]  = '{"mulhu",         MULHU,  1, 1, 0, 32'h0,        32'h1234_5678, 32'h9,       32'h1234_5678, 1};
    vecs[9]  = '{"mulhsu_m1x2",   MULHSU, 1, 1, 0, 32'h0,        32'h0,        32'd2,        32'hFFFF_FFFF, LAT_HI};
    vecs[10] = '{"mul_pos",       MUL,    1, 1, 0, 32'h0,        32'h0,        32'd6,        32'd6,         1};
    vecs[11] = '{"remu",          REMU,   1, 0, 0, 32'h0,        32'd3,        32'd7,        32'd3,         1};
    vecs[12] = '{"divu_zero",     DIVU,   0, 0, 1, 32'h7,        32'h0,        32'h0,        32'hFFFF_FFFF, 1};
    vecs[13] = '{"remu_zero",     REMU,   0, 0, 1, 32'h1234,     32'h0,        32'h0,        32'h0000_1234, 1};
    vecs[14] = '{"div_m9_3",      DIV,    0, 1, 0, 32'h0,        32'h0,        32'd3,        32'hFFFF_FFFD, 2};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_result", out_result, 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.issue_ready", 32'(issue_ready), 32'd1);
    rst = 1'b0;

    // res_valid while idle must be ignored
    res_valid = 1'b1;
    res_lo    = 32'hDEAD;
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
    check("idle_res.busy", 32'(busy), 32'd0);
    check("idle_res.out_valid", 32'(out_valid), 32'd0);

    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i].name, vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].dz, vecs[i].dvd,
            vecs[i].hi, vecs[i].lo, vecs[i].exp_r, vecs[i].lat);
    end

    // Backpressure: result held, issues and res pulses ignored
    out_ready = 1'b0;
    issue_valid = 1'b1; issue_opcode = MUL; issue_sign_1 = 1'b1; issue_sign_2 = 1'b0;
    issue_div_zero = 1'b0;
    @(negedge clk);
    issue_valid = 1'b0;
    res_valid = 1'b1; res_hi = 32'h0; res_lo = 32'd15;
    @(negedge clk);
    res_valid = 1'b0;
    @(negedge clk);
    check("bp.out_valid_first", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      res_valid = 1'b1; res_hi = $urandom; res_lo = $urandom; issue_valid = 1'b1;
      @(negedge clk);
      check("bp.out_valid", 32'(out_valid), 32'd1);
      check("bp.out_result", out_result, 32'hFFFF_FFF1);
      check("bp.issue_ready", 32'(issue_ready), 32'd0);
    end
    res_valid = 1'b0; issue_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("bp.out_valid_after", 32'(out_valid), 32'd0);
    check("bp.busy_after", 32'(busy), 32'd0);
    check("bp.issue_ready_after", 32'(issue_ready), 32'd1);

    // Reset while in NEG_LO
    issue_valid = 1'b1; issue_opcode = MULH; issue_sign_1 = 1'b1; issue_sign_2 = 1'b0;
    issue_div_zero = 1'b0;
    @(negedge clk);
    issue_valid = 1'b0;
    res_valid = 1'b1; res_hi = 32'h0; res_lo = 32'd1;
    @(negedge clk);
    res_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid.out_valid", 32'(out_valid), 32'd0);
    check("rstmid.busy", 32'(busy), 32'd0);
    check("rstmid.issue_ready", 32'(issue_ready), 32'd1);
    @(negedge clk);
    check("rstmid.out_valid_later", 32'(out_valid), 32'd0);
    do_op("rstmid.mul", MUL, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'd3, 32'hFFFF_FFFD, 2);

    // Randomized operations against the reference model
    for (int i = 0; i < 200; i++) begin
      op  = 5'($urandom_range(0, 10));
      s1  = 1'($urandom);
      s2  = 1'($urandom);
      dz  = ($urandom_range(0, 7) == 0);
      dvd = $urandom;
      hi  = $urandom;
      lo  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      model(op, s1, s2, dz, dvd, hi, lo, r_exp, l_exp);
      do_op("rand", op, s1, s2, dz, dvd, hi, lo, r_exp, l_exp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/result_converter.md
Name: result_converter

Overview:
- Output-side counterpart of the ALU operand converter.
- The converter strips operand signs so the multiply/divide core works on unsigned magnitudes; this block restores the sign on the core's unsigned result.
- Captures the operand sign tag at issue, waits for the core result, negates the selected word(s) over one or two cycles, and presents a 32-bit result on a valid/ready port.
- Sits between the multiply/divide core and the writeback mux.

Parameters:
- WIDTH, 32, data word width; res_hi/res_lo/out_result are WIDTH bits, product is 2*WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  sign tag offered
- issue_ready  out  1  block idle, tag accepted
- issue_opcode  in  5  ALU opcode of the operation
- issue_sign_1  in  1  bit 31 of original operator_1
- issue_sign_2  in  1  bit 31 of original operator_2
- issue_div_zero  in  1  divisor is zero
- issue_dividend  in  32  original operator_1, signed form
- res_valid  in  1  core result present (single-cycle pulse)
- res_hi  in  32  product[63:32] or remainder magnitude
- res_lo  in  32  product[31:0] or quotient magnitude
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_result  out  32  signed-corrected result
- busy  out  1  tag held (state != IDLE)

Behaviour:
- Reset (synchronous, active-high): state=IDLE, out_valid=0, out_result=0, busy=0, issue_ready=1, tag and carry registers=0. Reset mid-operation discards the held tag and result.
- States: IDLE -> WAIT_RES -> {NEG_LO -> [NEG_HI]} or direct -> OUT -> IDLE.
- IDLE: issue_ready=1. On issue_valid, latch opcode, signs, div_zero and dividend, then go to WAIT_RES.
- WAIT_RES: res_valid is sampled only here and ignored in all other states. On res_valid, latch res_hi/res_lo and compute the neg flag:
  - 00010 MUL: neg=s1^s2, select lo
  - 00011 MULH: neg=s1^s2, select hi
  - 00100 MULHSU: neg=s1, select hi
  - 00101 MULHU: no neg, select hi
  - 00110 DIV: neg=s1^s2, select lo
  - 01000 REM: neg=s1, select hi
  - 00111 DIVU / 01001 REMU / other: no neg
- Divide by zero:
  - DIV/DIVU with div_zero: result=32'hFFFFFFFF, no negation.
  - REM/REMU with div_zero: result=issue_dividend verbatim.
- neg=0 or div_zero: go to OUT; out_valid rises 1 cycle after res_valid.
- Negation is ~x+1 using the 32-bit word negator.
  - NEG_LO: lo_n=~res_lo+1, store carry_out.
  - Selection lo (MUL/DIV): result=lo_n, go to OUT; out_valid at res_valid+2.
  - REM: negate res_hi in NEG_LO with cin=1, go to OUT; out_valid at res_valid+2.
  - MULH/MULHSU: go to NEG_HI, hi_n=~res_hi+carry, go to OUT; out_valid at res_valid+3.
- OUT: out_valid=1, out_result held stable until out_valid&&out_ready, then go to IDLE with out_valid=0 next cycle. A new issue is accepted no earlier than the cycle after the handshake.
- Overflow cases need no special logic: -2^31/-1 gives magnitude 0x80000000 with equal signs, so the result is 0x80000000 unchanged; the remainder is 0.
- busy = state != IDLE.

Optional Feature:
- Macro RESULT_CONV_FAST_NEG_EN.
- Defined: 64-bit negation done in a single cycle (NEG_LO computes both halves, carry chained combinationally); NEG_HI state removed; all negated results at res_valid+2.
- Undefined: two-cycle split negation as above.

Decomposition:
- Shared package (alu_pkg):
  - 5-bit opcode constants (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU), shared with the operand converter
  - state encoding localparams
  - WIDTH default
- One sub-module, word_negator: 32-bit ~x+cin with carry_out. Instantiated once, or twice under RESULT_CONV_FAST_NEG_EN.

Test Plan:
- MUL -3*5: tag s1=1, s2=0; res_lo=15 -> out_result=0xFFFFFFF1 at res_valid+2.
- MULH -1*1: s1=1, s2=0; res_hi=0, res_lo=1 -> 0xFFFFFFFF at res_valid+3 (res_valid+2 with FAST); carry-propagation check with res_lo=0 -> hi_n=~hi+1.
- DIV by zero, dividend=-7: res ignored values -> 0xFFFFFFFF. REM by zero -> 0xFFFFFFF9. Both at res_valid+1.
- REM -7%2: s1=1; res_hi=1 -> 0xFFFFFFFF. DIVU 0x80000000/1 -> 0x80000000, no negation.
- Backpressure: out_ready=0 for 5 cycles -> out_result stable, issue_ready=0, res_valid pulses ignored; handshake -> IDLE next cycle.
- rst asserted in NEG_LO -> next cycle out_valid=0, busy=0, issue_ready=1; a following MUL completes correctly.
